// File: rtl/keypad_scan_pkg.sv
// Shared definitions for the keypad scanner: FSM states, key code width and
// small decode helpers used by the scanner datapath.
package keypad_scan_pkg;

    localparam int KEY_W = 4;

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2,
        ST_RELEASE  = 2'd3
    } kp_state_e;

    // Index of the lowest active-low row; the lowest row wins on multi-press.
    function automatic logic [1:0] lowest_low_row(input logic [3:0] rows);
        logic [1:0] idx;
        if (rows[0] == 1'b0) begin
            idx = 2'd0;
        end else if (rows[1] == 1'b0) begin
            idx = 2'd1;
        end else if (rows[2] == 1'b0) begin
            idx = 2'd2;
        end else begin
            idx = 2'd3;
        end
        return idx;
    endfunction

    // Active-low one-cold column drive for a column index.
    function automatic logic [3:0] col_drive(input logic [1:0] col);
        return ~(4'b0001 << col);
    endfunction

endpackage

// File: rtl/keypad_scan_tick_gen.sv
// Parameterised prescaler: emits a one-cycle tick every DIV clock cycles.
// Shared by the scanned peripherals (keypad, display multiplexer).
module scan_tick_gen #(
    parameter int DIV = 50000
) (
    input  logic clk_in,
    input  logic rst_n,
    output logic tick
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             tick_q;
    logic             tick_d;

    // Next count wraps at CNT_MAX; tick is registered so it is high while count == CNT_MAX.
    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        tick_d = (cnt_d == CNT_MAX);
    end

    // Prescaler state registers.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/keypad_scan.sv
// 4x4 active-low matrix keypad scanner: drives one column low at a time,
// debounces presses and releases, and reports one hex code per press.
module keypad_scan
    import keypad_scan_pkg::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic [3:0]       row_in,
    output logic [3:0]       col_out,
    output logic [KEY_W-1:0] key_code,
    output logic             key_valid,
    output logic             key_down
);

    localparam logic [3:0] DBC_LAST = 4'(DEBOUNCE_SCANS - 1);

    logic             tick_s;
    logic [3:0]       rows_meta_q;
    logic [3:0]       rows_sync_q;
    logic [3:0]       rows_s;
    logic             hit_s;
    logic [1:0]       row_s;
    logic [3:0]       dbc_inc_s;

    kp_state_e        state_q,     state_d;
    logic [1:0]       col_q,       col_d;
    logic [1:0]       cand_row_q,  cand_row_d;
    logic [3:0]       dbc_q,       dbc_d;
    logic [3:0]       col_out_q,   col_out_d;
    logic [KEY_W-1:0] key_code_q,  key_code_d;
    logic             key_valid_q, key_valid_d;
    logic             key_down_q,  key_down_d;

    scan_tick_gen #(
        .DIV (SCAN_DIV)
    ) u_tick (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .tick   (tick_s)
    );

    // Two-flop synchroniser for the asynchronous keypad rows (idle high).
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            rows_meta_q <= 4'b1111;
            rows_sync_q <= 4'b1111;
        end else begin
            rows_meta_q <= row_in;
            rows_sync_q <= rows_meta_q;
        end
    end

    assign rows_s    = rows_sync_q;
    assign hit_s     = (rows_s != 4'b1111);
    assign row_s     = lowest_low_row(rows_s);
    assign dbc_inc_s = dbc_q + 4'd1;

    // Scan/debounce FSM next-state logic; every decision is qualified by tick.
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        cand_row_d  = cand_row_q;
        dbc_d       = dbc_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_down_d  = key_down_q;
        if (tick_s) begin
            case (state_q)
                ST_SCAN: begin
                    if (hit_s) begin
                        cand_row_d = row_s;
                        dbc_d      = 4'd0;
                        state_d    = ST_DEBOUNCE;
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end
                ST_DEBOUNCE: begin
                    if (hit_s && (row_s == cand_row_q)) begin
                        dbc_d = dbc_inc_s;
                        if (dbc_inc_s >= DBC_LAST) begin
                            key_code_d  = {cand_row_q, col_q};
                            key_valid_d = 1'b1;
                            key_down_d  = 1'b1;
                            state_d     = ST_HELD;
                        end else begin
                            state_d = ST_DEBOUNCE;
                        end
                    end else begin
                        // Same column is rescanned: col is left untouched.
                        state_d = ST_SCAN;
                    end
                end
                ST_HELD: begin
                    if (!hit_s) begin
                        dbc_d   = 4'd0;
                        state_d = ST_RELEASE;
                    end else begin
                        state_d = ST_HELD;
                    end
                end
                ST_RELEASE: begin
                    if (!hit_s) begin
                        dbc_d = dbc_inc_s;
                        if (dbc_inc_s >= DBC_LAST) begin
                            key_down_d = 1'b0;
                            col_d      = col_q + 2'd1;
                            state_d    = ST_SCAN;
                        end else begin
                            state_d = ST_RELEASE;
                        end
                    end else begin
                        // Release bounce: back to held without a new report.
                        state_d = ST_HELD;
                    end
                end
                default: begin
                    state_d = ST_SCAN;
                end
            endcase
        end else begin
            state_d = state_q;
        end
        col_out_d = col_drive(col_d);
    end

    // FSM, column and output registers.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_SCAN;
            col_q       <= 2'd0;
            cand_row_q  <= 2'd0;
            dbc_q       <= 4'd0;
            col_out_q   <= 4'b1110;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            key_down_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            cand_row_q  <= cand_row_d;
            dbc_q       <= dbc_d;
            col_out_q   <= col_out_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_down_q  <= key_down_d;
        end
    end

    assign col_out   = col_out_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_down  = key_down_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan with SCAN_DIV=4, DEBOUNCE_SCANS=3. A physical keypad
// model turns a set of pressed keys into row levels from the driven column;
// expectations come from the key set and tick-count timing bounds.
module tb_keypad_scan;

    localparam int SCAN_DIV = 4;
    localparam int DEB      = 3;
    // Press: sync(2) + first tick + column walk + (DEB-1) ticks; bounded by (3+DEB) ticks + 3.
    localparam int LAT_MIN  = 3 + (DEB - 1) * SCAN_DIV;
    localparam int LAT_MAX  = (3 + DEB) * SCAN_DIV + 3;
    // Release: first idle tick 3..3+SCAN_DIV-1 edges, then DEB-1 more ticks.
    localparam int REL_MIN  = 3 + (DEB - 1) * SCAN_DIV;
    localparam int REL_MAX  = REL_MIN + SCAN_DIV - 1;

    logic        clk_in = 1'b0;
    logic        rst_n  = 1'b0;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_down;
    logic [15:0] pressed = 16'h0000;

    int          n_cmp     = 0;
    int          n_mis     = 0;
    int          valid_cnt = 0;
    logic        prev_valid = 1'b0;

    always #5 clk_in = ~clk_in;

    keypad_scan #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_SCANS (DEB)
    ) dut (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .row_in    (row_in),
        .col_out   (col_out),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_down  (key_down)
    );

    // Keypad matrix: a pressed key pulls its row low while its column is driven low.
    always_comb begin
        row_in = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Continuous monitor: one-cold column drive, single-cycle valid pulses, pulse count.
    always begin
        @(posedge clk_in);
        #1;
        check("col_onehot", $countones(col_out), 3);
        if (key_valid) begin
            check("valid_width", prev_valid, 0);
            valid_cnt++;
        end
        prev_valid = key_valid;
    end

    task automatic wait_edge();
        @(posedge clk_in);
        #2;
    endtask

    task automatic wait_edges(input int n);
        for (int i = 0; i < n; i++) wait_edge();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_col"},   col_out,   4'hE);
        check({tag, "_valid"}, key_valid, 0);
        check({tag, "_down"},  key_down,  0);
        check({tag, "_code"},  key_code,  0);
    endtask

    // Reset, then release with the given keys held; edge 1 is the next posedge.
    task automatic do_reset(input logic [15:0] mask);
        rst_n   = 1'b0;
        pressed = 16'h0000;
        wait_edges(2);
        check_reset_outputs("rst");
        pressed = mask;
        rst_n   = 1'b1;
    endtask

    // Hold a key set long enough to be accepted, optionally bounce on release.
    task automatic long_press(input logic [15:0] mask, input int exp_code, input bit bounce);
        int v0;
        int lat;
        int n;
        v0      = valid_cnt;
        pressed = mask;
        lat     = 0;
        while (valid_cnt == v0 && lat < 40) begin
            wait_edge();
            lat++;
        end
        check("press_count", valid_cnt - v0, 1);
        check("press_lat_ok", (lat >= LAT_MIN && lat <= LAT_MAX), 1);
        check("press_code", key_code, exp_code);
        check("press_down", key_down, 1);
        wait_edges($urandom_range(0, 20));
        check("hold_down", key_down, 1);
        if (bounce) begin
            pressed = 16'h0000;
            wait_edges($urandom_range(1, 6));
            check("bounce_gap_down", key_down, 1);
            pressed = mask;
            wait_edges($urandom_range(5, 8));
            check("bounce_down", key_down, 1);
        end
        pressed = 16'h0000;
        n = 0;
        while (key_down && n < 30) begin
            wait_edge();
            n++;
        end
        check("release_lat_ok", (n >= REL_MIN && n <= REL_MAX), 1);
        check("release_down", key_down, 0);
        check("single_report", valid_cnt - v0, 1);
        wait_edges(6);
    endtask

    initial begin
        logic [3:0]  exp_col;
        logic [15:0] mask;
        logic [3:0]  rows;
        int          col;
        int          code;
        int          kind;
        int          v0;

        // Reset values and free-running column walk.
        rst_n = 1'b0;
        wait_edges(2);
        check_reset_outputs("init");
        rst_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            wait_edge();
            exp_col = 4'b1111;
            exp_col[(k / SCAN_DIV) % 4] = 1'b0;
            check("col_step", col_out, exp_col);
        end

        // Row 1 low on column 0 for one tick only: no report, column 0 rescanned.
        do_reset(16'h0010);
        v0 = valid_cnt;
        wait_edges(5);
        pressed = 16'h0000;
        wait_edges(4);
        check("bounce_col_hold", col_out, 4'hE);
        wait_edges(3);
        check("bounce_col_next", col_out, 4'hD);
        check("bounce_no_valid", valid_cnt - v0, 0);
        wait_edges(8);

        // Clean press of key (2,2), multi-key on column 3, release bounce on key 5.
        long_press(16'h0400, 10, 1'b0);
        long_press(16'h8008, 3, 1'b0);
        long_press(16'h0020, 5, 1'b1);

        // Random key sets confined to one column; short presses must not report.
        for (int it = 0; it < 14; it++) begin
            col  = $urandom_range(0, 3);
            rows = 4'($urandom_range(1, 15));
            kind = $urandom_range(0, 2);
            mask = 16'h0000;
            code = -1;
            for (int r = 3; r >= 0; r--) begin
                if (rows[r]) begin
                    mask[r*4+col] = 1'b1;
                    code = r * 4 + col;
                end
            end
            if (kind == 0) begin
                v0      = valid_cnt;
                pressed = mask;
                wait_edges($urandom_range(1, 2 * SCAN_DIV - 1));
                pressed = 16'h0000;
                wait_edges(20);
                check("short_no_valid", valid_cnt - v0, 0);
                check("short_down", key_down, 0);
            end else begin
                long_press(mask, code, kind == 2);
            end
        end

        // Async reset while debouncing: row 1 pressed on every column.
        v0      = valid_cnt;
        pressed = 16'h00F0;
        wait_edges(8);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        pressed = 16'h0000;
        wait_edges(3);
        rst_n = 1'b1;
        wait_edges(20);
        check("async_no_valid", valid_cnt - v0, 0);
        check("async_down", key_down, 0);
        long_press(16'h8000, 15, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
